parking_gate_controller: RTL and testbench



---
 rtl/parking_gate_controller.sv | 150 +++++++++++++++
 tb/tb_parking_gate_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Parking lane gate controller: sensor synchronisation and debounce,
// passage-direction FSM, barrier arm command and entry/exit strobes.
module parking_gate_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned GATE_TIMEOUT    = 1000,
  parameter int unsigned TO_W            = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  input  logic lot_full,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic gate_open,
  output logic deny,
  output logic fault
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, DENY, FAULT
  } state_t;

  // Bit 0 carries sensor A, bit 1 carries sensor B.
  logic [1:0]      sync1_q, sync2_q, filt_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic            fa, fb;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;

  assign fa = filt_q[0];
  assign fb = filt_q[1];

  function automatic logic is_passage(input state_t s);
    return (s == IN_A) || (s == IN_AB) || (s == IN_B) ||
           (s == OUT_B) || (s == OUT_BA) || (s == OUT_A);
  endfunction

  // Two-flop synchroniser followed by a stability counter per sensor.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {sensor_b, sensor_a};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_q[i]   <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Next-state decode on the filtered pattern, with the passage timeout on top.
  always_comb begin
    state_d = state_q;
    to_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (fa && !fb)      state_d = lot_full ? DENY : IN_A;
        else if (!fa && fb) state_d = OUT_B;
        else if (fa && fb)  state_d = FAULT;
      end
      IN_A: begin
        if (fa && fb)        state_d = IN_AB;
        else if (!fa && fb)  state_d = IN_B;
        else if (!fa && !fb) state_d = IDLE;
      end
      IN_AB: begin
        if (!fa && fb)       state_d = IN_B;
        else if (fa && !fb)  state_d = IN_A;
        else if (!fa && !fb) state_d = IDLE;
      end
      IN_B: begin
        if (!fa && !fb)      state_d = IDLE;
        else if (fa && fb)   state_d = IN_AB;
        else if (fa && !fb)  state_d = IN_A;
      end
      OUT_B: begin
        if (fa && fb)        state_d = OUT_BA;
        else if (fa && !fb)  state_d = OUT_A;
        else if (!fa && !fb) state_d = IDLE;
      end
      OUT_BA: begin
        if (fa && !fb)       state_d = OUT_A;
        else if (!fa && fb)  state_d = OUT_B;
        else if (!fa && !fb) state_d = IDLE;
      end
      OUT_A: begin
        if (!fa && !fb)      state_d = IDLE;
        else if (fa && fb)   state_d = OUT_BA;
        else if (!fa && fb)  state_d = OUT_B;
      end
      DENY: begin
        // A vehicle reaching B past a lowered arm is a fault, not a passage.
        if (fb)              state_d = FAULT;
        else if (!fa)        state_d = IDLE;
        else if (!lot_full)  state_d = IN_A;
      end
      FAULT: begin
        if (!fa && !fb)      state_d = IDLE;
      end
      default:               state_d = IDLE;
    endcase

    if (is_passage(state_q) && (state_d == state_q) &&
        (to_q == TO_W'(GATE_TIMEOUT - 1))) begin
      state_d = FAULT;
    end

    if (is_passage(state_q) && (state_d == state_q)) begin
      to_d = to_q + TO_W'(1);
    end
  end

  // State, timeout counter and registered Moore outputs / completion strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      to_q        <= '0;
      gate_open   <= 1'b0;
      deny        <= 1'b0;
      fault       <= 1'b0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_q        <= to_d;
      gate_open   <= is_passage(state_d) || (state_d == FAULT);
      deny        <= (state_d == DENY);
      fault       <= (state_d == FAULT);
      entry_pulse <= (state_q == IN_B)  && (state_d == IDLE);
      exit_pulse  <= (state_q == OUT_A) && (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: scenario stimulus with a pulse scoreboard.
module tb_parking_gate_controller;

  logic clk = 1'b0;
  logic reset, sensor_a, sensor_b, lot_full;
  logic entry_pulse, exit_pulse, gate_open, deny, fault;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q [$];  // 1 = entry strobe expected, 2 = exit strobe expected

  parking_gate_controller #(
    .DEBOUNCE_CYCLES(4),
    .GATE_TIMEOUT   (50),
    .TO_W           (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sensor_a   (sensor_a),
    .sensor_b   (sensor_b),
    .lot_full   (lot_full),
    .entry_pulse(entry_pulse),
    .exit_pulse (exit_pulse),
    .gate_open  (gate_open),
    .deny       (deny),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    cyc(n);
  endtask

  // Every observed strobe must match the next expected one, in order.
  always @(negedge clk) begin
    if (!reset && (entry_pulse || exit_pulse)) begin
      check_eq("pulse_excl", 32'(entry_pulse & exit_pulse), 0);
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("pulse_kind", entry_pulse ? 1 : 2, exp_q.pop_front());
    end
  end

  initial begin
    int lat;
    int t_gate;
    int t_fault;
    logic seen;

    reset = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0; lot_full = 1'b0;
    cyc(3);
    check_eq("rst_gate",  gate_open,   0);
    check_eq("rst_deny",  deny,        0);
    check_eq("rst_fault", fault,       0);
    check_eq("rst_entry", entry_pulse, 0);
    check_eq("rst_exit",  exit_pulse,  0);
    reset = 1'b0;
    cyc(2);

    // Entry with free space.
    exp_q.push_back(1);
    sensor_a = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (gate_open && lat == 0) lat = k;
    end
    check_eq("entry_gate_lat_6_7", 32'(lat >= 6 && lat <= 7), 1);
    check_eq("entry_deny", deny, 0);
    drive(1, 1, 10);
    check_eq("entry_ab_gate", gate_open, 1);
    drive(0, 1, 10);
    check_eq("entry_b_gate", gate_open, 1);
    sensor_b = 1'b0;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      if (entry_pulse && lat == 0) lat = k;
    end
    check_eq("entry_pulse_lat_7_8", 32'(lat >= 7 && lat <= 8), 1);
    check_eq("entry_gate_closed", gate_open, 0);
    check_eq("entry_sb_empty", exp_q.size(), 0);

    // Exit is honoured even with the lot full.
    lot_full = 1'b1;
    exp_q.push_back(2);
    drive(0, 1, 10);
    check_eq("exit_gate", gate_open, 1);
    check_eq("exit_deny", deny, 0);
    drive(1, 1, 10);
    drive(1, 0, 10);
    check_eq("exit_a_gate", gate_open, 1);
    drive(0, 0, 12);
    check_eq("exit_sb_empty", exp_q.size(), 0);
    check_eq("exit_gate_closed", gate_open, 0);

    // Full lot refuses, then admits once space frees up.
    drive(1, 0, 20);
    check_eq("full_deny", deny, 1);
    check_eq("full_gate", gate_open, 0);
    lot_full = 1'b0;
    cyc(2);
    check_eq("freed_gate", gate_open, 1);
    check_eq("freed_deny", deny, 0);
    drive(0, 0, 12);
    check_eq("freed_abort_gate", gate_open, 0);
    check_eq("freed_sb_empty", exp_q.size(), 0);

    // Backed-out vehicle: no strobe.
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(1, 0, 10);
    drive(0, 0, 12);
    check_eq("abort_gate", gate_open, 0);
    check_eq("abort_fault", fault, 0);
    check_eq("abort_sb_empty", exp_q.size(), 0);

    // Short raw glitch on B must never reach the FSM.
    seen = 1'b0;
    for (int k = 0; k < 23; k++) begin
      sensor_b = (k < 3);
      cyc(1);
      if (gate_open || fault) seen = 1'b1;
    end
    check_eq("glitch_no_open", seen, 0);

    // Vehicle parked under the arm trips the timeout.
    sensor_a = 1'b1;
    t_gate = 0;
    t_fault = 0;
    for (int k = 1; k <= 62; k++) begin
      cyc(1);
      if (gate_open && t_gate == 0) t_gate = k;
      if (fault && t_fault == 0) t_fault = k;
    end
    check_eq("to_fault", fault, 1);
    check_eq("to_gate", gate_open, 1);
    check_eq("to_delay", t_fault - t_gate, 50);
    drive(0, 0, 12);
    check_eq("to_clear_fault", fault, 0);
    check_eq("to_clear_gate", gate_open, 0);
    check_eq("to_sb_empty", exp_q.size(), 0);

    // Reset mid-passage drops the vehicle without a strobe.
    drive(1, 0, 10);
    drive(1, 1, 10);
    drive(0, 1, 10);
    check_eq("pre_rst_gate", gate_open, 1);
    reset = 1'b1;
    sensor_b = 1'b0;
    cyc(1);
    check_eq("mid_rst_gate",  gate_open,   0);
    check_eq("mid_rst_deny",  deny,        0);
    check_eq("mid_rst_fault", fault,       0);
    check_eq("mid_rst_entry", entry_pulse, 0);
    check_eq("mid_rst_exit",  exit_pulse,  0);
    reset = 1'b0;
    cyc(20);
    check_eq("post_rst_gate", gate_open, 0);
    check_eq("post_rst_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
